game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game sequencer that drives the UI overlay renderer and the stage datapath. Owns the screen state (title, help, stages, success, fail, staff roll), title and result menu cursor, stage objectives, key count, lives, stage unlock mask and sprint-stamina bar. All outputs are registered and feed the overlay's `state`, `todo`, `key_find`, `life`, `play_valid` and `shift` inputs directly.

## Interface
- `STAMINA_MAX`, default 55: full stamina bar width in half-resolution pixels; must be less than 64.
- `DRAIN`, default 2: stamina lost per `tick` while sprinting.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle frame-rate pulse.
- `btn_up`, `btn_down`, `btn_enter`  in  1 each  debounced one-cycle button pulses.
- `shift_held`  in  1  sprint key level.
- `key_hit`, `light_hit`, `door_hit`, `hazard_hit`  in  1 each  one-cycle collision pulses from the stage datapath.
- `state`  out  4  TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8, HELP=9.
- `menu_sel`  out  2  cursor index on the current menu.
- `todo`  out  2  NONE=0, FIND_KEY=1, FIND_LIGHT=2, FIND_DOOR=3.
- `key_find`  out  2  keys collected, 0..3.
- `life`  out  2  lives remaining, 0..3.
- `play_valid`  out  4  stage unlock mask; bit n set means stage n is playable.
- `shift`  out  6  stamina bar width, 0..STAMINA_MAX.
- `sprint_ok`  out  1  sprint permitted this cycle.

## Operation
- Reset values: `state`=TITLE, `menu_sel`=0, `todo`=NONE, `key_find`=0, `life`=3, `play_valid`=4'b0010, `shift`=STAMINA_MAX, `last_stage`=STAGE1.
- Buttons, all states:
  - `btn_enter` has priority over up/down in the same cycle; up/down are then dropped.
  - `btn_up` and `btn_down` together: no move.
  - Cursor saturates at the ends; no wrap.
- `menu_sel` clears to 0 on every `state` change.
- TITLE: `menu_sel` 0..3 selects stage1, stage2, stage3, help.
  - Enter on 0 goes to STAGE1.
  - Enter on 1 goes to STAGE2 only if `play_valid[2]`; on 2 goes to STAGE3 only if `play_valid[3]`. Enter on a locked stage is ignored and the state holds.
  - Enter on 3 goes to HELP.
- Stage entry (from any state): `key_find`=0, `life`=3, `shift`=STAMINA_MAX; `last_stage` takes the stage entered.
  - `todo` = FIND_LIGHT for STAGE2, FIND_KEY otherwise.
- In a stage, at most one collision event is processed per cycle; the rest are dropped. Priority order: door, key, light, hazard.
  - `door_hit` with `todo`=FIND_DOOR: go to SUCCESSn; set `play_valid[n+1]` (n=1,2). `door_hit` is ignored otherwise.
  - `key_hit` with `todo`=FIND_KEY: `key_find`+1. When it reaches 3, `todo` becomes FIND_DOOR in the same update. `key_hit` is ignored otherwise.
  - `light_hit` in STAGE2 with `todo`=FIND_LIGHT: `todo` becomes FIND_KEY. Ignored elsewhere.
  - `hazard_hit` in STAGE3 only: `life`-1. From `life`=1, `life` becomes 0 and `state` goes to FAIL.
  - `btn_enter` is ignored in stages.
- SUCCESS1/2 menu: 0=next, 1=back.
  - Enter on next goes to the following stage, with full stage entry.
  - Enter on back goes to TITLE.
- SUCCESS3: enter goes to STAFF.
- FAIL menu: 0=retry, 1=back.
  - Enter on retry re-enters `last_stage`.
  - Enter on back goes to TITLE.
- STAFF, HELP: enter goes to TITLE.
- `play_valid` is cleared only by `rst_n`. Bit 0 is always 0; bit 1 is always 1.
- Stamina, applied on `tick` in stage states only:
  - `shift_held` and `shift`>0: `shift` = max(`shift`−DRAIN, 0).
  - `shift_held` deasserted: `shift` = min(`shift`+1, STAMINA_MAX).
  - Otherwise hold.
- `sprint_ok` = stage state AND `shift_held` AND `shift`≠0. This is the only combinational output.

## Timing
- Event or button pulse sampled at edge N; all registered outputs reflect it after edge N.
- State transition and entry initialisation land on the same edge.
- Stamina update on a `tick` edge coincident with a stage entry: entry initialisation wins.
- `rst_n` assertion mid-stage immediately forces all reset values, independent of `clk`. Release is synchronised externally.

## Configuration
- `GAME_CHEAT_EN` defined:
  - `play_valid` resets to 4'b1110.
  - `hazard_hit` never decrements `life`, so FAIL is unreachable.
- `GAME_CHEAT_EN` undefined: behaviour exactly as above.

## Test plan
- Reset, then down ×2 and enter: state stays 0 (stage3 locked). Up ×3: `menu_sel`=0. Enter: state=2, todo=1, life=3, shift=55.
- STAGE1: key_hit ×4, then door_hit: `key_find` goes 1,2,3 and `todo`=3 after the third hit; the fourth is ignored. Door: state=3, play_valid=4'b0110.
- STAGE2: key_hit before light_hit is ignored. light_hit: todo=1. key_hit and door_hit in the same cycle: key counted, door dropped.
- STAGE3: hazard_hit ×3: life 2,1, then state=8, life=0. Enter on retry: state=6, life=3.
- Stage with shift_held high for 30 ticks: shift=0, sprint_ok=0. Release for 10 ticks: shift=10.
- `GAME_CHEAT_EN`: after reset play_valid=4'b1110; STAGE3 with hazard_hit ×5 leaves life=3.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game screen sequencer: menus, stage objectives, lives, unlock mask and sprint stamina.
// Optional build macro GAME_CHEAT_EN: all stages unlocked at reset and hazards never cost a life.
module game_flow_ctrl #(
    parameter int STAMINA_MAX = 55,
    parameter int DRAIN       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       shift_held,
    input  logic       key_hit,
    input  logic       light_hit,
    input  logic       door_hit,
    input  logic       hazard_hit,
    output logic [3:0] state,
    output logic [1:0] menu_sel,
    output logic [1:0] todo,
    output logic [1:0] key_find,
    output logic [1:0] life,
    output logic [3:0] play_valid,
    output logic [5:0] shift,
    output logic       sprint_ok
);

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8,
        ST_HELP     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        TODO_NONE  = 2'd0,
        TODO_KEY   = 2'd1,
        TODO_LIGHT = 2'd2,
        TODO_DOOR  = 2'd3
    } todo_t;

    localparam logic [5:0] SHIFT_FULL = 6'(STAMINA_MAX);
    localparam logic [5:0] DRAIN_W    = 6'(DRAIN);

`ifdef GAME_CHEAT_EN
    localparam logic [1:0] PLAY_HI_RST = 2'b11;
    localparam logic       HAZARD_EN   = 1'b0;
`else
    localparam logic [1:0] PLAY_HI_RST = 2'b00;
    localparam logic       HAZARD_EN   = 1'b1;
`endif

    state_t     r_state, w_state_nxt;
    state_t     r_last_stage, w_last_nxt;
    todo_t      r_todo, w_todo_nxt;
    logic [1:0] r_menu_sel, w_menu_nxt;
    logic [1:0] r_key_find, w_key_nxt;
    logic [1:0] r_life, w_life_nxt;
    logic [1:0] r_play_hi, w_play_nxt;   // play_valid[3:2]; bits 1:0 are fixed
    logic [5:0] r_shift, w_shift_nxt;

    logic       w_is_stage;
    logic [1:0] w_menu_max;
    logic       w_enter_stage;
    state_t     w_stage_tgt;

    assign w_is_stage = (r_state == ST_STAGE1) || (r_state == ST_STAGE2) ||
                        (r_state == ST_STAGE3);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_menu_max = 2'd0;
        case (r_state)
            ST_TITLE:                           w_menu_max = 2'd3;
            ST_SUCCESS1, ST_SUCCESS2, ST_FAIL:  w_menu_max = 2'd1;
            default:                            w_menu_max = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last_stage;
        w_todo_nxt    = r_todo;
        w_menu_nxt    = r_menu_sel;
        w_key_nxt     = r_key_find;
        w_life_nxt    = r_life;
        w_play_nxt    = r_play_hi;
        w_shift_nxt   = r_shift;
        w_enter_stage = 1'b0;
        w_stage_tgt   = ST_STAGE1;

        if (!btn_enter) begin
            if (btn_up && !btn_down && (r_menu_sel != 2'd0))
                w_menu_nxt = r_menu_sel - 2'd1;
            else if (btn_down && !btn_up && (r_menu_sel < w_menu_max))
                w_menu_nxt = r_menu_sel + 2'd1;
        end

        if (w_is_stage && tick) begin
            if (shift_held) begin
                if (r_shift != 6'd0)
                    w_shift_nxt = (r_shift > DRAIN_W) ? (r_shift - DRAIN_W) : 6'd0;
            end else if (r_shift < SHIFT_FULL) begin
                w_shift_nxt = r_shift + 6'd1;
            end
        end

        case (r_state)
            ST_TITLE: begin
                if (btn_enter) begin
                    case (r_menu_sel)
                        2'd0: begin
                            w_enter_stage = 1'b1;
                            w_stage_tgt   = ST_STAGE1;
                        end
                        2'd1: begin
                            w_enter_stage = r_play_hi[0];
                            w_stage_tgt   = ST_STAGE2;
                        end
                        2'd2: begin
                            w_enter_stage = r_play_hi[1];
                            w_stage_tgt   = ST_STAGE3;
                        end
                        default: w_state_nxt = ST_HELP;
                    endcase
                end
            end
            ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
                // Only the highest-priority event that applies right now is taken.
                if (door_hit && (r_todo == TODO_DOOR)) begin
                    case (r_state)
                        ST_STAGE1: begin
                            w_state_nxt   = ST_SUCCESS1;
                            w_play_nxt[0] = 1'b1;
                        end
                        ST_STAGE2: begin
                            w_state_nxt   = ST_SUCCESS2;
                            w_play_nxt[1] = 1'b1;
                        end
                        default: w_state_nxt = ST_SUCCESS3;
                    endcase
                end else if (key_hit && (r_todo == TODO_KEY)) begin
                    w_key_nxt = r_key_find + 2'd1;
                    if (r_key_find == 2'd2)
                        w_todo_nxt = TODO_DOOR;
                end else if (light_hit && (r_state == ST_STAGE2) && (r_todo == TODO_LIGHT)) begin
                    w_todo_nxt = TODO_KEY;
                end else if (hazard_hit && HAZARD_EN && (r_state == ST_STAGE3)) begin
                    if (r_life <= 2'd1) begin
                        w_life_nxt  = 2'd0;
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_life_nxt = r_life - 2'd1;
                    end
                end
            end
            ST_SUCCESS1: begin
                if (btn_enter) begin
                    if (r_menu_sel == 2'd0) begin
                        w_enter_stage = 1'b1;
                        w_stage_tgt   = ST_STAGE2;
                    end else begin
                        w_state_nxt = ST_TITLE;
                    end
                end
            end
            ST_SUCCESS2: begin
                if (btn_enter) begin
                    if (r_menu_sel == 2'd0) begin
                        w_enter_stage = 1'b1;
                        w_stage_tgt   = ST_STAGE3;
                    end else begin
                        w_state_nxt = ST_TITLE;
                    end
                end
            end
            ST_SUCCESS3: begin
                if (btn_enter)
                    w_state_nxt = ST_STAFF;
            end
            ST_FAIL: begin
                if (btn_enter) begin
                    if (r_menu_sel == 2'd0) begin
                        w_enter_stage = 1'b1;
                        w_stage_tgt   = r_last_stage;
                    end else begin
                        w_state_nxt = ST_TITLE;
                    end
                end
            end
            default: begin
                if (btn_enter)
                    w_state_nxt = ST_TITLE;
            end
        endcase

        // Entry initialisation overrides any stamina update on the same edge.
        if (w_enter_stage) begin
            w_state_nxt = w_stage_tgt;
            w_last_nxt  = w_stage_tgt;
            w_key_nxt   = 2'd0;
            w_life_nxt  = 2'd3;
            w_shift_nxt = SHIFT_FULL;
            w_todo_nxt  = (w_stage_tgt == ST_STAGE2) ? TODO_LIGHT : TODO_KEY;
        end

        if (w_state_nxt != r_state)
            w_menu_nxt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_state      <= ST_TITLE;
            r_last_stage <= ST_STAGE1;
            r_todo       <= TODO_NONE;
            r_menu_sel   <= 2'd0;
            r_key_find   <= 2'd0;
            r_life       <= 2'd3;
            r_play_hi    <= PLAY_HI_RST;
            r_shift      <= SHIFT_FULL;
        end else begin
            r_state      <= w_state_nxt;
            r_last_stage <= w_last_nxt;
            r_todo       <= w_todo_nxt;
            r_menu_sel   <= w_menu_nxt;
            r_key_find   <= w_key_nxt;
            r_life       <= w_life_nxt;
            r_play_hi    <= w_play_nxt;
            r_shift      <= w_shift_nxt;
        end
    end

    assign state      = r_state;
    assign menu_sel   = r_menu_sel;
    assign todo       = r_todo;
    assign key_find   = r_key_find;
    assign life       = r_life;
    assign play_valid = {r_play_hi, 2'b10};
    assign shift      = r_shift;
    assign sprint_ok  = w_is_stage && shift_held && (r_shift != 6'd0);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus randomized play
// compared every cycle against a rule-level model of the game flow.
module tb_game_flow_ctrl;

    localparam int SMAX = 55;
    localparam int DR   = 2;
`ifdef GAME_CHEAT_EN
    localparam int PV_RESET = 14;
`else
    localparam int PV_RESET = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, btn_up, btn_down, btn_enter, shift_held;
    logic       key_hit, light_hit, door_hit, hazard_hit;
    logic [3:0] state;
    logic [1:0] menu_sel, todo, key_find, life;
    logic [3:0] play_valid;
    logic [5:0] shift;
    logic       sprint_ok;

    always #5 clk = ~clk;

    game_flow_ctrl #(.STAMINA_MAX(SMAX), .DRAIN(DR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_enter  (btn_enter),
        .shift_held (shift_held),
        .key_hit    (key_hit),
        .light_hit  (light_hit),
        .door_hit   (door_hit),
        .hazard_hit (hazard_hit),
        .state      (state),
        .menu_sel   (menu_sel),
        .todo       (todo),
        .key_find   (key_find),
        .life       (life),
        .play_valid (play_valid),
        .shift      (shift),
        .sprint_ok  (sprint_ok)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: screen numbers as in the state encoding table, menus as list lengths.
    int m_state, m_sel, m_todo, m_keys, m_life, m_pv, m_shift, m_last;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_stage(input int s);
        return (s == 2) || (s == 4) || (s == 6);
    endfunction

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_todo = 0; m_keys = 0;
        m_life  = 3; m_pv  = PV_RESET; m_shift = SMAX; m_last = 2;
    endtask

    task automatic model_step(input bit t, u, d, e, sh, k, l, dr, hz);
        int ns    = m_state;
        int nsel  = m_sel;
        int ntodo = m_todo;
        int nkeys = m_keys;
        int nlife = m_life;
        int npv   = m_pv;
        int nsh   = m_shift;
        int nlast = m_last;
        int tgt   = -1;
        int menu_len;
        menu_len = (m_state == 0) ? 4 : ((m_state == 3 || m_state == 5 || m_state == 8) ? 2 : 1);
        if (!e) begin
            if (u && !d && nsel > 0) nsel = nsel - 1;
            else if (d && !u && nsel < menu_len - 1) nsel = nsel + 1;
        end
        if (in_stage(m_state)) begin
            if (t) begin
                if (sh && m_shift > 0) nsh = (m_shift > DR) ? m_shift - DR : 0;
                else if (!sh) nsh = (m_shift + 1 > SMAX) ? SMAX : m_shift + 1;
            end
            if (dr && m_todo == 3) begin
                ns = m_state + 1;
                if (m_state != 6) npv = m_pv | (1 << (m_state / 2 + 1));
            end else if (k && m_todo == 1) begin
                nkeys = m_keys + 1;
                if (nkeys == 3) ntodo = 3;
            end else if (l && m_state == 4 && m_todo == 2) begin
                ntodo = 1;
            end else if (hz && m_state == 6) begin
`ifndef GAME_CHEAT_EN
                nlife = m_life - 1;
                if (nlife == 0) ns = 8;
`endif
            end
        end else if (e) begin
            case (m_state)
                0: begin
                    if (m_sel == 0) tgt = 2;
                    else if (m_sel == 1) begin if ((m_pv >> 2) & 1) tgt = 4; end
                    else if (m_sel == 2) begin if ((m_pv >> 3) & 1) tgt = 6; end
                    else ns = 9;
                end
                3: if (m_sel == 0) tgt = 4; else ns = 0;
                5: if (m_sel == 0) tgt = 6; else ns = 0;
                7: ns = 1;
                8: if (m_sel == 0) tgt = m_last; else ns = 0;
                default: ns = 0;
            endcase
        end
        if (tgt >= 0) begin
            ns = tgt; nlast = tgt; nkeys = 0; nlife = 3; nsh = SMAX;
            ntodo = (tgt == 4) ? 2 : 1;
        end
        if (ns != m_state) nsel = 0;
        m_state = ns; m_sel = nsel; m_todo = ntodo; m_keys = nkeys;
        m_life = nlife; m_pv = npv; m_shift = nsh; m_last = nlast;
    endtask

    task automatic check_all();
        check("state", int'(state), m_state);
        check("menu_sel", int'(menu_sel), m_sel);
        check("todo", int'(todo), m_todo);
        check("key_find", int'(key_find), m_keys);
        check("life", int'(life), m_life);
        check("play_valid", int'(play_valid), m_pv);
        check("shift", int'(shift), m_shift);
    endtask

    task automatic check_reset_literals();
        check("rst_state", int'(state), 0);
        check("rst_menu_sel", int'(menu_sel), 0);
        check("rst_todo", int'(todo), 0);
        check("rst_key_find", int'(key_find), 0);
        check("rst_life", int'(life), 3);
        check("rst_play_valid", int'(play_valid), PV_RESET);
        check("rst_shift", int'(shift), SMAX);
    endtask

    // One clock: drive at the falling edge, check before and after the rising edge.
    task automatic step(input bit t, u, d, e, sh, k, l, dr, hz);
        tick = t; btn_up = u; btn_down = d; btn_enter = e; shift_held = sh;
        key_hit = k; light_hit = l; door_hit = dr; hazard_hit = hz;
        #1;
        check("sprint_ok", int'(sprint_ok),
              (in_stage(m_state) && sh && m_shift != 0) ? 1 : 0);
        model_step(t, u, d, e, sh, k, l, dr, hz);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic btn(input bit u, d, e);
        step(1'b0, u, d, e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hit(input bit k, l, dr, hz);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k, l, dr, hz);
    endtask

    task automatic ticks(input bit sh, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, sh, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_literals();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tick = 0; btn_up = 0; btn_down = 0; btn_enter = 0; shift_held = 0;
        key_hit = 0; light_hit = 0; door_hit = 0; hazard_hit = 0;
        rst_n = 1'b0;
        #12;
        check_reset_literals();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef GAME_CHEAT_EN
        btn(0, 1, 0); btn(0, 1, 0); btn(0, 0, 1);
        check("cheat_stage3", int'(state), 6);
        for (int i = 0; i < 5; i++) hit(0, 0, 0, 1);
        check("cheat_life", int'(life), 3);
        @(posedge clk);
        #2;
        do_reset();
`endif

        // Title menu: locked stage3, saturating cursor, up+down cancels.
        btn(0, 1, 0); btn(0, 1, 0); btn(0, 0, 1);
`ifndef GAME_CHEAT_EN
        check("title_locked", int'(state), 0);
`endif
        btn(1, 1, 0);
        btn(1, 0, 0); btn(1, 0, 0); btn(1, 0, 0);
        check("title_sel_sat", int'(menu_sel), 0);
        btn(0, 0, 1);
`ifndef GAME_CHEAT_EN
        check("enter_s1_state", int'(state), 2);
        check("enter_s1_todo", int'(todo), 1);
        check("enter_s1_life", int'(life), 3);
        check("enter_s1_shift", int'(shift), SMAX);
`endif
        // Stage1: three keys then door; extra key ignored.
        for (int i = 0; i < 4; i++) hit(1, 0, 0, 0);
        hit(0, 0, 1, 0);
`ifndef GAME_CHEAT_EN
        check("s1_success", int'(state), 3);
        check("s1_unlock", int'(play_valid), 6);
`endif
        // Stage2: key before light ignored, then key beats door.
        btn(0, 0, 1);
        hit(1, 0, 0, 0);
        hit(0, 1, 0, 0);
        hit(1, 0, 1, 0);
`ifndef GAME_CHEAT_EN
        check("s2_key_over_door", int'(key_find), 1);
        check("s2_stay", int'(state), 4);
`endif
        hit(1, 0, 0, 0); hit(1, 0, 0, 0); hit(0, 0, 1, 0);
        btn(0, 0, 1);
        // Stage3: lose all lives, then retry.
        for (int i = 0; i < 3; i++) hit(0, 0, 0, 1);
`ifndef GAME_CHEAT_EN
        check("s3_fail_state", int'(state), 8);
        check("s3_fail_life", int'(life), 0);
`endif
        btn(0, 0, 1);
`ifndef GAME_CHEAT_EN
        check("retry_state", int'(state), 6);
        check("retry_life", int'(life), 3);
`endif
        // Stamina drain to empty, then recovery.
        ticks(1'b1, 30);
        shift_held = 1'b1;
        #1;
        check("stamina_empty", int'(shift), 0);
        check("sprint_blocked", int'(sprint_ok), 0);
        @(negedge clk);
        ticks(1'b0, 10);
        check("stamina_recover", int'(shift), 10);

        // Asynchronous reset between clock edges while in a stage.
        @(posedge clk);
        #2;
        do_reset();

        // Randomized play against the model.
        begin
            bit held = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 7) == 0) held = ~held;
                step($urandom_range(0, 2) == 0,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 6) == 0,
                     held,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 9) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
